fetch_prefetch_unit: RTL

//   Instruction-fetch front end that sits directly upstream of the fetch->execute latches.

---
 rtl/riscv_pkg.sv | 20 ++
 rtl/fetch_queue.sv | 61 ++++++
 rtl/fetch_prefetch_unit.sv | 107 ++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared fetch-side types and constants for the RV32 front end.
// No logic; types only.
// Not applicable (no handshake).
package riscv_pkg;

  localparam int XLEN = 32;

  // Canonical NOP (addi x0, x0, 0)
  localparam logic [XLEN-1:0] INST_NOP = 32'h0000_0013;

  // Fetch PC after reset unless the top overrides it
  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  // One queued instruction together with the PC it was fetched from
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } pc_inst_t;

endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO of pc_inst_t entries between the IMEM response path and execute.
// Latency: a push becomes visible at head one cycle later (registered storage, no bypass).
// Backpressure: none internally; the caller's credit scheme keeps push off a full queue.
module fetch_queue
  import riscv_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  pc_inst_t         push_data,
  input  logic             pop,
  input  logic             flush,
  output logic [CNT_W-1:0] count,
  output pc_inst_t         head
);

  localparam int PTR_W = $clog2(DEPTH);

  pc_inst_t         mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Flush wins over both push and pop; a pop on an empty queue is ignored.
  assign do_push = push && !flush;
  assign do_pop  = pop && !flush && (count != '0);

  assign head = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; pointers wrap naturally (DEPTH is a power of 2).
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // Entry storage; cleared on reset so the head reads as zero out of reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // A push into a full queue without a simultaneous pop would lose data.
  assert property (@(posedge clk) disable iff (rst)
    !(do_push && !do_pop && (count == CNT_W'(DEPTH))))
    else $error("fetch_queue: push while full");

endmodule

// File: rtl/fetch_prefetch_unit.sv
// Fetch front end: owns the fetch PC, issues credit-limited IMEM requests, queues responses for execute.
// Latency: request fire at t, response at t+k, out_valid at t+k+1.
// Backpressure: requests stall while inflight + queued reaches DEPTH; redirect suppresses issue for that cycle.
module fetch_prefetch_unit
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int          DEPTH    = 4,
  parameter int          CNT_W    = $clog2(DEPTH) + 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_inst
);

  logic [31:0]      fetch_pc;
  logic [31:0]      rsp_pc;
  logic [CNT_W-1:0] inflight;
  logic [CNT_W-1:0] discard;
  logic [CNT_W-1:0] occupancy;
  logic [CNT_W:0]   credit_sum;
  logic [31:0]      redirect_target;
  logic             req_fire;
  logic             rsp_push;
  logic             pop;
  pc_inst_t         push_data;
  pc_inst_t         head;
  logic             unused_redirect_lsbs;

  assign redirect_target      = {redirect_pc[31:2], 2'b00};
  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  // Every accepted request is pre-allocated a queue slot, so responses can always be pushed.
  assign credit_sum     = {1'b0, inflight} + {1'b0, occupancy};
  assign imem_req_valid = !rst && !redirect_valid && (credit_sum < (CNT_W+1)'(DEPTH));
  assign imem_req_addr  = fetch_pc;
  assign req_fire       = imem_req_valid && imem_req_ready;

  // A response is kept only when it is not owed to an older redirect and no redirect is happening now.
  assign rsp_push  = imem_rsp_valid && !redirect_valid && (discard == '0);
  assign push_data = '{pc: rsp_pc, inst: imem_rsp_data};
  assign pop       = out_valid && out_ready;

  assign out_valid = (occupancy != '0);
  assign out_pc    = head.pc;
  assign out_inst  = head.inst;

  fetch_queue #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_queue (
    .clk       (clk),
    .rst       (rst),
    .push      (rsp_push),
    .push_data (push_data),
    .pop       (pop),
    .flush     (redirect_valid),
    .count     (occupancy),
    .head      (head)
  );

  // Request PC advances per accepted request; response tag PC advances per kept response.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
      rsp_pc   <= RESET_PC;
    end else if (redirect_valid) begin
      fetch_pc <= redirect_target;
      rsp_pc   <= redirect_target;
    end else begin
      if (req_fire) fetch_pc <= fetch_pc + 32'd4;
      if (rsp_push) rsp_pc   <= rsp_pc + 32'd4;
    end
  end

  // inflight counts every outstanding response, including those already marked for discard,
  // so on a redirect every response still outstanding becomes stale.
  always_ff @(posedge clk) begin
    if (rst) begin
      inflight <= '0;
      discard  <= '0;
    end else if (redirect_valid) begin
      inflight <= inflight - CNT_W'(imem_rsp_valid);
      discard  <= inflight - CNT_W'(imem_rsp_valid);
    end else begin
      inflight <= inflight + CNT_W'(req_fire) - CNT_W'(imem_rsp_valid);
      if (imem_rsp_valid && (discard != '0)) discard <= discard - CNT_W'(1);
    end
  end

  assert property (@(posedge clk) disable iff (rst) credit_sum <= (CNT_W+1)'(DEPTH))
    else $error("fetch_prefetch_unit: inflight + occupancy exceeds DEPTH");

  assert property (@(posedge clk) disable iff (rst) discard <= CNT_W'(DEPTH))
    else $error("fetch_prefetch_unit: discard exceeds DEPTH");

endmodule
